// File: rtl/openmips_pkg.sv
// rtl/openmips_pkg.sv - shared OpenMIPS widths, NOP address, MEM payload type and pipe action decode
package openmips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int CNT_W_DEF  = 2;
    localparam int BCNT_W_DEF = 16;

    // Register 0 is hard-wired zero, so writing it is harmless: bubbles target it.
    localparam logic [ADDR_W_DEF-1:0] NOP_REG_ADDR = '0;

    typedef struct packed {
        logic                  valid;
        logic                  wen;
        logic [ADDR_W_DEF-1:0] waddr;
        logic [DATA_W_DEF-1:0] wdata;
        logic                  whilo;
        logic [DATA_W_DEF-1:0] hi;
        logic [DATA_W_DEF-1:0] lo;
    } mem_payload_t;

    typedef enum logic [1:0] {
        ACT_FLUSH,
        ACT_BUBBLE,
        ACT_HOLD,
        ACT_ADVANCE
    } pipe_act_t;

    // Per-cycle action, flush > bubble > hold > advance (reset handled by the flops).
    // stall_mem=1 with stall_ex=0 cannot come from control; it falls into hold.
    function automatic pipe_act_t decode_action(input logic flush,
                                                input logic stall_ex,
                                                input logic stall_mem);
        pipe_act_t act;
        if (flush)
            act = ACT_FLUSH;
        else if (stall_ex && !stall_mem)
            act = ACT_BUBBLE;
        else if (stall_mem)
            act = ACT_HOLD;
        else
            act = ACT_ADVANCE;
        return act;
    endfunction

endpackage

// File: rtl/ex_mem_pipe_if.sv
// rtl/ex_mem_pipe_if.sv - EX-side inputs and MEM-side outputs of the EX/MEM pipeline register
// master: the pipeline register (reads i_*, drives o_*); slave: the surrounding EX/MEM stages.
interface ex_mem_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2,
    parameter int BCNT_W = 16
);
    logic                  i_ex_valid;
    logic                  i_ex_wen;
    logic [ADDR_W-1:0]     i_ex_waddr;
    logic [DATA_W-1:0]     i_ex_wdata;
    logic                  i_ex_whilo;
    logic [DATA_W-1:0]     i_ex_hi;
    logic [DATA_W-1:0]     i_ex_lo;
    logic [2*DATA_W-1:0]   i_hilo_temp;
    logic [CNT_W-1:0]      i_cnt;

    logic                  o_mem_valid;
    logic                  o_mem_wen;
    logic [ADDR_W-1:0]     o_mem_waddr;
    logic [DATA_W-1:0]     o_mem_wdata;
    logic                  o_mem_whilo;
    logic [DATA_W-1:0]     o_mem_hi;
    logic [DATA_W-1:0]     o_mem_lo;
    logic [2*DATA_W-1:0]   o_hilo_temp;
    logic [CNT_W-1:0]      o_cnt;
    logic [BCNT_W-1:0]     o_bubble_cnt;

    modport master (
        input  i_ex_valid, i_ex_wen, i_ex_waddr, i_ex_wdata,
        input  i_ex_whilo, i_ex_hi, i_ex_lo, i_hilo_temp, i_cnt,
        output o_mem_valid, o_mem_wen, o_mem_waddr, o_mem_wdata,
        output o_mem_whilo, o_mem_hi, o_mem_lo, o_hilo_temp, o_cnt, o_bubble_cnt
    );

    modport slave (
        output i_ex_valid, i_ex_wen, i_ex_waddr, i_ex_wdata,
        output i_ex_whilo, i_ex_hi, i_ex_lo, i_hilo_temp, i_cnt,
        input  o_mem_valid, o_mem_wen, o_mem_waddr, o_mem_wdata,
        input  o_mem_whilo, o_mem_hi, o_mem_lo, o_hilo_temp, o_cnt, o_bubble_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with increment, hold and clear
// Ports: clk_i, rst_i (sync active-high), inc_i (+1 unless all-ones), clr_i (to zero, wins over inc), cnt_o.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/ex_mem_pipe.sv
// rtl/ex_mem_pipe.sv - EX->MEM pipeline register with stall/flush, bubble insertion and bubble counter
// Ports: i_clk, i_rst (sync active-high), i_stall_ex, i_stall_mem, i_flush, bus (ex_mem_pipe_if.master).
// Build option EX_MEM_HILO_EN: when defined, HI/LO write-back, hilo_temp and cnt registers exist;
// otherwise those outputs are tied to 0 and only the GPR path and bubble counter are built.
module ex_mem_pipe
    import openmips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int BCNT_W = BCNT_W_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_stall_ex,
    input  logic          i_stall_mem,
    input  logic          i_flush,
    ex_mem_pipe_if.master bus
);
    pipe_act_t act;
    assign act = decode_action(i_flush, i_stall_ex, i_stall_mem);

    // GPR write-back path
    logic              valid_q, valid_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    always_comb begin
        valid_d = valid_q;
        wen_d   = wen_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (act)
            ACT_FLUSH, ACT_BUBBLE: begin
                valid_d = 1'b0;
                wen_d   = 1'b0;
                waddr_d = ADDR_W'(NOP_REG_ADDR);
                wdata_d = '0;
            end
            ACT_ADVANCE: begin
                valid_d = bus.i_ex_valid;
                // A squashed EX slot must never commit, whatever its wen says.
                wen_d   = bus.i_ex_wen & bus.i_ex_valid;
                waddr_d = bus.i_ex_waddr;
                wdata_d = bus.i_ex_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            wen_q   <= 1'b0;
            waddr_q <= ADDR_W'(NOP_REG_ADDR);
            wdata_q <= '0;
        end else begin
            valid_q <= valid_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.o_mem_valid = valid_q;
    assign bus.o_mem_wen   = wen_q;
    assign bus.o_mem_waddr = waddr_q;
    assign bus.o_mem_wdata = wdata_q;

`ifdef EX_MEM_HILO_EN
    // HI/LO write-back and the madd/msub accumulate state looped back to EX
    logic                whilo_q, whilo_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [2*DATA_W-1:0] temp_q, temp_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    always_comb begin
        whilo_d = whilo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        temp_d  = temp_q;
        cnt_d   = cnt_q;
        case (act)
            ACT_FLUSH: begin
                whilo_d = 1'b0;
                hi_d    = '0;
                lo_d    = '0;
                temp_d  = '0;
                cnt_d   = '0;
            end
            ACT_BUBBLE: begin
                // EX is iterating a multi-cycle op: park its partial result for the next step.
                whilo_d = 1'b0;
                hi_d    = '0;
                lo_d    = '0;
                temp_d  = bus.i_hilo_temp;
                cnt_d   = bus.i_cnt;
            end
            ACT_ADVANCE: begin
                whilo_d = bus.i_ex_whilo & bus.i_ex_valid;
                hi_d    = bus.i_ex_hi;
                lo_d    = bus.i_ex_lo;
                temp_d  = '0;
                cnt_d   = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            whilo_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            temp_q  <= '0;
            cnt_q   <= '0;
        end else begin
            whilo_q <= whilo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            temp_q  <= temp_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_mem_whilo = whilo_q;
    assign bus.o_mem_hi    = hi_q;
    assign bus.o_mem_lo    = lo_q;
    assign bus.o_hilo_temp = temp_q;
    assign bus.o_cnt       = cnt_q;
`else
    logic unused_hilo_inputs;
    assign unused_hilo_inputs = ^{bus.i_ex_whilo, bus.i_ex_hi, bus.i_ex_lo, bus.i_hilo_temp, bus.i_cnt};

    assign bus.o_mem_whilo = 1'b0;
    assign bus.o_mem_hi    = '0;
    assign bus.o_mem_lo    = '0;
    assign bus.o_hilo_temp = '0;
    assign bus.o_cnt       = '0;
`endif

    // Flush does not clear the counter: it measures EX stall pressure across exceptions.
    sat_counter #(.W(BCNT_W)) u_bubble_cnt (
        .clk_i (i_clk),
        .rst_i (i_rst),
        .inc_i (act == ACT_BUBBLE),
        .clr_i (1'b0),
        .cnt_o (bus.o_bubble_cnt)
    );
endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb/tb_ex_mem_pipe.sv - scoreboard bench for ex_mem_pipe with a behavioural reference model
module tb_ex_mem_pipe;
    import openmips_pkg::*;

`ifdef EX_MEM_HILO_EN
    localparam bit HILO_EN = 1'b1;
`else
    localparam bit HILO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0, flush = 1'b0, stall_ex = 1'b0, stall_mem = 1'b0;
    always #5 clk = ~clk;

    ex_mem_pipe_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(2), .BCNT_W(16)) bus ();
    ex_mem_pipe_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(2), .BCNT_W(2))  bus_s ();

    ex_mem_pipe #(.DATA_W(32), .ADDR_W(5), .CNT_W(2), .BCNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_stall_ex(stall_ex), .i_stall_mem(stall_mem),
        .i_flush(flush), .bus(bus)
    );
    ex_mem_pipe #(.DATA_W(32), .ADDR_W(5), .CNT_W(2), .BCNT_W(2)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_stall_ex(stall_ex), .i_stall_mem(stall_mem),
        .i_flush(flush), .bus(bus_s)
    );

    typedef struct {
        mem_payload_t pay;
        logic [63:0]  temp;
        logic [1:0]   cnt;
        int           bcnt;
        int           bcnt_s;
    } exp_t;

    exp_t m;
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // current stimulus
    logic        s_rst, s_flush, s_sex, s_smem, s_v, s_wen, s_whilo;
    logic [4:0]  s_waddr;
    logic [31:0] s_wdata, s_hi, s_lo;
    logic [63:0] s_temp;
    logic [1:0]  s_cnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic rand_stim();
        s_rst = 0; s_flush = 0; s_sex = 0; s_smem = 0;
        s_v = 1'($urandom); s_wen = 1'($urandom); s_whilo = 1'($urandom);
        s_waddr = 5'($urandom); s_wdata = $urandom; s_hi = $urandom; s_lo = $urandom;
        s_temp = {$urandom, $urandom}; s_cnt = 2'($urandom);
    endtask

    // Reference behaviour: one cycle of the pipeline register described by its rules.
    task automatic model_cycle();
        if (s_rst) begin
            m.pay = '0; m.temp = '0; m.cnt = '0; m.bcnt = 0; m.bcnt_s = 0;
        end else if (s_flush) begin
            m.pay = '0; m.temp = '0; m.cnt = '0;
        end else if (s_sex && !s_smem) begin
            m.pay  = '0;
            m.temp = HILO_EN ? s_temp : 64'd0;
            m.cnt  = HILO_EN ? s_cnt : 2'd0;
            if (m.bcnt < 65535) m.bcnt++;
            if (m.bcnt_s < 3) m.bcnt_s++;
        end else if (s_smem) begin
            // nothing changes
        end else begin
            m.pay.valid = s_v;
            m.pay.wen   = s_v && s_wen;
            m.pay.waddr = s_waddr;
            m.pay.wdata = s_wdata;
            m.pay.whilo = HILO_EN && s_v && s_whilo;
            m.pay.hi    = HILO_EN ? s_hi : 32'd0;
            m.pay.lo    = HILO_EN ? s_lo : 32'd0;
            m.temp = '0;
            m.cnt  = '0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        rst = s_rst; flush = s_flush; stall_ex = s_sex; stall_mem = s_smem;
        bus.i_ex_valid = s_v;     bus_s.i_ex_valid = s_v;
        bus.i_ex_wen = s_wen;     bus_s.i_ex_wen = s_wen;
        bus.i_ex_waddr = s_waddr; bus_s.i_ex_waddr = s_waddr;
        bus.i_ex_wdata = s_wdata; bus_s.i_ex_wdata = s_wdata;
        bus.i_ex_whilo = s_whilo; bus_s.i_ex_whilo = s_whilo;
        bus.i_ex_hi = s_hi;       bus_s.i_ex_hi = s_hi;
        bus.i_ex_lo = s_lo;       bus_s.i_ex_lo = s_lo;
        bus.i_hilo_temp = s_temp; bus_s.i_hilo_temp = s_temp;
        bus.i_cnt = s_cnt;        bus_s.i_cnt = s_cnt;
        model_cycle();
        sb.push_back(m);
    endtask

    // Monitor: the register presents a new output every cycle, checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("valid", 64'(bus.o_mem_valid), 64'(e.pay.valid));
                chk("wen",   64'(bus.o_mem_wen),   64'(e.pay.wen));
                chk("waddr", 64'(bus.o_mem_waddr), 64'(e.pay.waddr));
                chk("wdata", 64'(bus.o_mem_wdata), 64'(e.pay.wdata));
                chk("whilo", 64'(bus.o_mem_whilo), 64'(e.pay.whilo));
                chk("hi",    64'(bus.o_mem_hi),    64'(e.pay.hi));
                chk("lo",    64'(bus.o_mem_lo),    64'(e.pay.lo));
                chk("hilo_temp", bus.o_hilo_temp,  e.temp);
                chk("cnt",   64'(bus.o_cnt),       64'(e.cnt));
                chk("bubble_cnt",   64'(bus.o_bubble_cnt),   64'(e.bcnt));
                chk("bubble_cnt_w2", 64'(bus_s.o_bubble_cnt), 64'(e.bcnt_s));
                chk("w2_wdata", 64'(bus_s.o_mem_wdata), 64'(e.pay.wdata));
            end
        end
    end

    initial begin
        m = '{pay: '0, temp: '0, cnt: '0, bcnt: 0, bcnt_s: 0};
        rand_stim();
        // reset with nonzero inputs, 2 cycles
        s_v = 1; s_wen = 1; s_waddr = 5'd7; s_wdata = 32'hFFFF_FFFF; s_sex = 1;
        s_rst = 1; step(); s_rst = 1; step();
        // advance
        rand_stim(); s_v = 1; s_wen = 1; s_waddr = 5'd5; s_wdata = 32'hDEADBEEF; step();
        // advance of an invalid slot
        rand_stim(); s_v = 0; s_wen = 1; s_whilo = 1; step();
        // bubble carrying madd partial state
        rand_stim(); s_sex = 1; s_temp = 64'h1_0000_0002; s_cnt = 2'd1; step();
        // second madd step advances
        rand_stim(); s_v = 1; step();
        // hold: load 0x1234 then stall MEM for 3 cycles with changing inputs
        rand_stim(); s_v = 1; s_wen = 1; s_wdata = 32'h1234; step();
        for (int i = 0; i < 3; i++) begin
            rand_stim(); s_smem = 1; s_sex = 1'(i & 1); step();
        end
        // bubble to set temp/cnt, then flush over stall
        rand_stim(); s_sex = 1; s_cnt = 2'd2; step();
        rand_stim(); s_flush = 1; s_sex = 1; step();
        // saturation of the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            rand_stim(); s_sex = 1; step();
        end
        // random traffic
        for (int i = 0; i < 400; i++) begin
            rand_stim();
            s_rst   = ($urandom_range(0, 59) == 0);
            s_flush = ($urandom_range(0, 15) == 0);
            s_sex   = ($urandom_range(0, 3) == 0);
            s_smem  = ($urandom_range(0, 4) == 0);
            step();
        end
        // drain, bounded
        for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
        #3;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
